serial_tx_arbiter: RTL

Shares one 8N1 serial transmit line between four byte requesters using round-robin arbitration. The block times bits with an internal DDFS phase accumulator whose carry-out is a single-cycle bit-enable, so all logic runs in the `CLK` domain. It sits between the board's message sources (score, timer, status, debug) and the UART TX pin, and it replaces per-source transmitters.

---
 rtl/serial_tx_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: four byte requesters share one 8N1 TX line.
// Round-robin grant in IDLE; bit timing from a DDFS phase accumulator.
//
// Parameters:
//   K    - phase increment per CLK (1 <= K < 2**N)
//   N    - accumulator width; bit rate = F_CLK * K / 2**N
// Ports:
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-high reset
//   REQ  - level request per requester, held until its GNT
//   DATA - byte i on DATA[8i+7:8i], stable while REQ[i] is high
//   GNT  - one-hot, one-cycle pulse: byte i captured
//   BUSY - high while a frame is in progress
//   SRC  - index of the most recently granted requester
//   TX   - serial line, idle high
module serial_tx_arbiter #(
   parameter int unsigned K = 1,
   parameter int unsigned N = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  REQ,
   input  logic [31:0] DATA,
   output logic [3:0]  GNT,
   output logic        BUSY,
   output logic [1:0]  SRC,
   output logic        TX
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   localparam logic [N:0] KINC = (N+1)'(K);

   state_t       state_q, state_d;
   logic [N-1:0] acc_q, acc_d;
   logic [7:0]   shift_q, shift_d;
   logic [2:0]   cnt_q, cnt_d;
   logic [3:0]   gnt_q, gnt_d;
   logic         busy_q, busy_d;
   logic [1:0]   src_q, src_d;
   logic         tx_q, tx_d;

   logic [N:0]   acc_sum;
   logic         tick;
   logic         win_vld;
   logic [1:0]   win_idx;

   // Carry out of the phase accumulator is the bit-enable.
   assign acc_sum = {1'b0, acc_q} + KINC;
   assign tick    = acc_sum[N];

   // Round-robin search starting one past the last winner. The loop
   // runs from the farthest candidate to the nearest so that the
   // nearest requesting index is the last (winning) assignment.
   always_comb begin
      logic [1:0] idx;
      idx     = '0;
      win_vld = 1'b0;
      win_idx = src_q;
      for (int i = 4; i >= 1; i--) begin
         idx = src_q + 2'(i);
         if (REQ[idx]) begin
            win_vld = 1'b1;
            win_idx = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_sum[N-1:0];
      shift_d = shift_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      src_d   = src_q;
      tx_d    = tx_q;
      unique case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (win_vld) begin
               shift_d = DATA[{win_idx, 3'b000} +: 8];
               src_d   = win_idx;
               gnt_d   = 4'b0001 << win_idx;
               tx_d    = 1'b0;
               // Phase-align every frame to its start bit.
               acc_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               tx_d    = shift_q[0];
               cnt_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (cnt_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
                  cnt_d   = cnt_q + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         src_q   <= 2'd3;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         src_q   <= src_d;
         tx_q    <= tx_d;
      end
   end

   assign GNT  = gnt_q;
   assign BUSY = busy_q;
   assign SRC  = src_q;
   assign TX   = tx_q;

   a_gnt_onehot: assert property (
      @(posedge CLK) disable iff (RST) $onehot0(gnt_q));

   a_gnt_in_start: assert property (
      @(posedge CLK) disable iff (RST)
      (gnt_q != 4'b0000) |-> (state_q == S_START));

   a_busy_state: assert property (
      @(posedge CLK) disable iff (RST)
      busy_q == (state_q != S_IDLE));

endmodule
